// File: rtl/tdm_demux_2ch.sv
// Two-channel TDM bit-serial demultiplexer: hunts for frame_sync, then splits the
// interleaved stream (ch0 slot first, MSB-first) into two WIDTH-bit words.
module tdm_demux_2ch #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             din,
    input  logic             din_valid,
    input  logic             frame_sync,
    output logic [WIDTH-1:0] ch0_data,
    output logic             ch0_valid,
    output logic [WIDTH-1:0] ch1_data,
    output logic             ch1_valid,
    output logic             locked,
    output logic             sync_err
);
    localparam int BW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [BW-1:0] LAST = BW'(WIDTH - 1);

    typedef enum logic {HUNT, RUN} state_t;

    state_t           state;
    logic             slot;
    logic [BW-1:0]    bit_idx;
    logic [WIDTH-1:0] sh0, sh1;

    logic [WIDTH-1:0] sh0_next, sh1_next, first_bit;
    assign sh0_next  = {sh0[WIDTH-2:0], din};
    assign sh1_next  = {sh1[WIDTH-2:0], din};
    assign first_bit = {{(WIDTH-1){1'b0}}, din};

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= HUNT;
            slot      <= 1'b0;
            bit_idx   <= '0;
            sh0       <= '0;
            sh1       <= '0;
            ch0_data  <= '0;
            ch1_data  <= '0;
            ch0_valid <= 1'b0;
            ch1_valid <= 1'b0;
            locked    <= 1'b0;
            sync_err  <= 1'b0;
        end else begin
            ch0_valid <= 1'b0;
            ch1_valid <= 1'b0;
            sync_err  <= 1'b0;
            if (din_valid) begin
                case (state)
                    HUNT: begin
                        if (frame_sync) begin
                            sh0     <= first_bit;
                            sh1     <= '0;
                            slot    <= 1'b1;
                            bit_idx <= '0;
                            state   <= RUN;
                            locked  <= 1'b1;
                        end
                    end
                    RUN: begin
                        if (frame_sync && (slot || bit_idx != '0)) begin
                            // Misplaced sync: drop both partial words and restart the frame on this bit.
                            sync_err <= 1'b1;
                            sh0      <= first_bit;
                            sh1      <= '0;
                            slot     <= 1'b1;
                            bit_idx  <= '0;
                        end else if (!slot) begin
                            sh0  <= sh0_next;
                            slot <= 1'b1;
                            if (bit_idx == LAST) begin
                                ch0_data  <= sh0_next;
                                ch0_valid <= 1'b1;
                            end
                        end else begin
                            sh1  <= sh1_next;
                            slot <= 1'b0;
                            if (bit_idx == LAST) begin
                                ch1_data  <= sh1_next;
                                ch1_valid <= 1'b1;
                                bit_idx   <= '0;
                            end else begin
                                bit_idx <= bit_idx + 1'b1;
                            end
                        end
                    end
                    default: state <= HUNT;
                endcase
            end
        end
    end
endmodule
